// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: states, opcodes,
// ALU codes, datapath select encodings and the bundled control-word type.
package mips_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_FWAIT,
        S_DECODE,
        S_EXEC,
        S_MADDR,
        S_MWAIT,
        S_WB,
        S_FAULT
    } state_e;

    // Opcodes are zero-extended to the configured opcode width at the point of use.
    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_SLI = 1;
    localparam int unsigned OP_J   = 2;
    localparam int unsigned OP_JAL = 3;
    localparam int unsigned OP_LW  = 4;
    localparam int unsigned OP_SW  = 5;
    localparam int unsigned OP_BEQ = 6;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLLI = 3'b010;
    localparam logic [2:0] ALU_ADDR = 3'b011;

    localparam logic [1:0] DST_RT  = 2'b00;
    localparam logic [1:0] DST_RD  = 2'b01;
    localparam logic [1:0] DST_R31 = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MDR = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    typedef struct packed {
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [2:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       jump;
        logic       branch;
        logic       pc_write;
        logic       ir_load;
        logic       mov;
        logic       rw;
        logic       mar_en;
        logic       mdr_en;
        logic       fault;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait-cycle counter for the MOV/MOC handshake; expired_o flags the
// wait cycle on which a missing MOC would reach MEM_TIMEOUT.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    localparam int CW = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CW'(MEM_TIMEOUT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q >= CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with MOV/MOC memory handshake, illegal-opcode
// detection and a bounded memory wait that drops into a sticky FAULT state.
//   state  | meaning
//   FETCH  | PC -> MAR, arm wait timer
//   FWAIT  | instruction read in flight, wait for MOC
//   DECODE | latch opcode, dispatch (J completes here)
//   EXEC   | ALU op for ADD/SLI/BEQ
//   MADDR  | effective address -> MAR (SW also loads MDR)
//   MWAIT  | data access in flight, wait for MOC
//   WB     | register write-back
//   FAULT  | absorbing until reset
module multicycle_control
    import mips_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                MOC,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic [2:0]          alu_op,
    output logic                alu_src,
    output logic                reg_write,
    output logic                jump,
    output logic                branch,
    output logic                pc_write,
    output logic                ir_load,
    output logic                MOV,
    output logic                RW,
    output logic                MAREnable,
    output logic                MDREnable,
    output logic                fault,
    output logic                instr_done
);

    localparam logic [OPCODE_W-1:0] K_ADD = OPCODE_W'(OP_ADD);
    localparam logic [OPCODE_W-1:0] K_SLI = OPCODE_W'(OP_SLI);
    localparam logic [OPCODE_W-1:0] K_J   = OPCODE_W'(OP_J);
    localparam logic [OPCODE_W-1:0] K_JAL = OPCODE_W'(OP_JAL);
    localparam logic [OPCODE_W-1:0] K_LW  = OPCODE_W'(OP_LW);
    localparam logic [OPCODE_W-1:0] K_SW  = OPCODE_W'(OP_SW);
    localparam logic [OPCODE_W-1:0] K_BEQ = OPCODE_W'(OP_BEQ);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic                tmr_clear, tmr_en, tmr_expired;
    ctrl_t               ctrl, ctrl_o;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (tmr_clear),
        .enable_i  (tmr_en),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        ctrl      = '0;
        unique case (state_q)
            S_FETCH: begin
                ctrl.mar_en = 1'b1;
                tmr_clear   = 1'b1;
                state_d     = S_FWAIT;
            end
            S_FWAIT: begin
                ctrl.mov = 1'b1;
                ctrl.rw  = 1'b1;
                if (MOC) begin
                    ctrl.mdr_en   = 1'b1;
                    ctrl.ir_load  = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_d       = S_DECODE;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expired) state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (opcode == K_ADD || opcode == K_SLI || opcode == K_BEQ) begin
                    state_d = S_EXEC;
                end else if (opcode == K_J) begin
                    ctrl.jump       = 1'b1;
                    ctrl.pc_write   = 1'b1;
                    ctrl.instr_done = 1'b1;
                    state_d         = S_FETCH;
                end else if (opcode == K_JAL) begin
                    state_d = S_WB;
                end else if (opcode == K_LW || opcode == K_SW) begin
                    state_d = S_MADDR;
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_EXEC: begin
                if (op_q == K_BEQ) begin
                    ctrl.alu_op     = ALU_SUB;
                    ctrl.branch     = 1'b1;
                    ctrl.pc_write   = zero;
                    ctrl.instr_done = 1'b1;
                    state_d         = S_FETCH;
                end else begin
                    ctrl.alu_op  = (op_q == K_SLI) ? ALU_SLLI : ALU_ADD;
                    ctrl.alu_src = (op_q == K_SLI);
                    state_d      = S_WB;
                end
            end
            S_MADDR: begin
                ctrl.alu_op  = ALU_ADDR;
                ctrl.alu_src = 1'b1;
                ctrl.mar_en  = 1'b1;
                ctrl.mdr_en  = (op_q == K_SW);
                tmr_clear    = 1'b1;
                state_d      = S_MWAIT;
            end
            S_MWAIT: begin
                ctrl.mov = 1'b1;
                ctrl.rw  = (op_q == K_LW);
                if (MOC) begin
                    ctrl.mdr_en     = (op_q == K_LW);
                    ctrl.instr_done = (op_q != K_LW);
                    state_d         = (op_q == K_LW) ? S_WB : S_FETCH;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expired) state_d = S_FAULT;
                end
            end
            S_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
                if (op_q == K_ADD) begin
                    ctrl.reg_dst = DST_RD;
                end else if (op_q == K_LW) begin
                    ctrl.mem_to_reg = WB_MDR;
                end else if (op_q == K_JAL) begin
                    ctrl.reg_dst    = DST_R31;
                    ctrl.mem_to_reg = WB_PC;
                    ctrl.jump       = 1'b1;
                    ctrl.pc_write   = 1'b1;
                end
            end
            S_FAULT: begin
                ctrl.fault = 1'b1;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held, whatever state the register is in.
    assign ctrl_o     = reset ? '0 : ctrl;
    assign reg_dst    = ctrl_o.reg_dst;
    assign mem_to_reg = ctrl_o.mem_to_reg;
    assign alu_op     = ctrl_o.alu_op;
    assign alu_src    = ctrl_o.alu_src;
    assign reg_write  = ctrl_o.reg_write;
    assign jump       = ctrl_o.jump;
    assign branch     = ctrl_o.branch;
    assign pc_write   = ctrl_o.pc_write;
    assign ir_load    = ctrl_o.ir_load;
    assign MOV        = ctrl_o.mov;
    assign RW         = ctrl_o.rw;
    assign MAREnable  = ctrl_o.mar_en;
    assign MDREnable  = ctrl_o.mdr_en;
    assign fault      = ctrl_o.fault;
    assign instr_done = ctrl_o.instr_done;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected output traces are built
// from the instruction's phase list, played cycle by cycle and compared each cycle.
module tb_multicycle_control;

    localparam int OPW = 6;
    localparam int TMO = 15;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           zero = 1'b0;
    logic           MOC = 1'b0;
    logic [OPW-1:0] opcode = '0;
    logic [1:0]     reg_dst, mem_to_reg;
    logic [2:0]     alu_op;
    logic           alu_src, reg_write, jump, branch, pc_write, ir_load;
    logic           MOV, RW, MAREnable, MDREnable, fault, instr_done;

    multicycle_control #(.OPCODE_W(OPW), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .MOC(MOC),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_op(alu_op), .alu_src(alu_src),
        .reg_write(reg_write), .jump(jump), .branch(branch), .pc_write(pc_write),
        .ir_load(ir_load), .MOV(MOV), .RW(RW), .MAREnable(MAREnable),
        .MDREnable(MDREnable), .fault(fault), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [2:0] alu_op;
        logic alu_src, reg_write, jump, branch, pc_write, ir_load;
        logic mov, rw, mar_en, mdr_en, fault, instr_done;
    } out_t;

    typedef struct {
        logic           moc;
        logic           zero;
        logic [OPW-1:0] opc;
        out_t           exp;
    } step_t;

    step_t trace[$];
    out_t  cur_exp = '0;
    out_t  dut_v;
    logic  chk_en = 1'b0;
    int    n_tests = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    lat_cnt = 0;
    int    last_lat = 0;
    int    mov_run = 0;
    int    last_run = 0;

    assign dut_v = {reg_dst, mem_to_reg, alu_op, alu_src, reg_write, jump, branch,
                    pc_write, ir_load, MOV, RW, MAREnable, MDREnable, fault, instr_done};

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            n_tests++;
            if (dut_v !== cur_exp) begin
                n_fail++;
                $display("FAIL cycle %0d outputs: got %05h expected %05h", cyc, dut_v, cur_exp);
            end
            if (reset) lat_cnt = 0;
            else lat_cnt++;
            if (instr_done) begin
                last_lat = lat_cnt;
                lat_cnt  = 0;
            end
            if (MOV) mov_run++;
            else if (mov_run != 0) begin
                last_run = mov_run;
                mov_run  = 0;
            end
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [OPW-1:0] ropc();
        return OPW'($urandom);
    endfunction

    task automatic push(input logic moc, input logic z, input logic [OPW-1:0] opc, input out_t e);
        step_t s;
        s.moc = moc; s.zero = z; s.opc = opc; s.exp = e;
        trace.push_back(s);
    endtask

    task automatic fault_tail();
        out_t e;
        for (int i = 0; i < 3; i++) begin
            e = '0; e.fault = 1'b1;
            push(rb(), rb(), ropc(), e);
        end
    endtask

    // A wait phase lasts until MOC arrives (after 'delay' idle cycles) or TMO idle cycles pass.
    task automatic mem_phase(input int delay, input logic rw, input out_t done_x, output bit ok);
        out_t e;
        ok = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            e = '0; e.mov = 1'b1; e.rw = rw;
            if (i == delay) begin
                e = out_t'(e | done_x);
                push(1'b1, rb(), ropc(), e);
                ok = 1'b1;
                return;
            end
            push(1'b0, rb(), ropc(), e);
        end
    endtask

    task automatic build(input int op, input int df, input int dd, input logic z, output bit faults);
        out_t e, d;
        bit ok;
        faults = 1'b0;
        e = '0; e.mar_en = 1'b1;
        push(rb(), rb(), ropc(), e);
        d = '0; d.mdr_en = 1'b1; d.ir_load = 1'b1; d.pc_write = 1'b1;
        mem_phase(df, 1'b1, d, ok);
        if (!ok) begin fault_tail(); faults = 1'b1; return; end
        e = '0;
        if (op == 2) begin e.jump = 1'b1; e.pc_write = 1'b1; e.instr_done = 1'b1; end
        push(rb(), rb(), OPW'(op), e);
        if (op > 6) begin fault_tail(); faults = 1'b1; return; end
        if (op == 0 || op == 1) begin
            e = '0; e.alu_src = (op == 1); e.alu_op = (op == 1) ? 3'b010 : 3'b000;
            push(rb(), rb(), ropc(), e);
        end
        if (op == 6) begin
            e = '0; e.alu_op = 3'b001; e.branch = 1'b1; e.pc_write = z; e.instr_done = 1'b1;
            push(rb(), z, ropc(), e);
        end
        if (op == 4 || op == 5) begin
            e = '0; e.alu_op = 3'b011; e.alu_src = 1'b1; e.mar_en = 1'b1; e.mdr_en = (op == 5);
            push(rb(), rb(), ropc(), e);
            d = '0;
            if (op == 4) d.mdr_en = 1'b1;
            else d.instr_done = 1'b1;
            mem_phase(dd, (op == 4), d, ok);
            if (!ok) begin fault_tail(); faults = 1'b1; return; end
        end
        if (op == 0 || op == 1 || op == 3 || op == 4) begin
            e = '0; e.reg_write = 1'b1; e.instr_done = 1'b1;
            if (op == 0) e.reg_dst = 2'b01;
            if (op == 4) e.mem_to_reg = 2'b01;
            if (op == 3) begin
                e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; e.jump = 1'b1; e.pc_write = 1'b1;
            end
            push(rb(), rb(), ropc(), e);
        end
    endtask

    task automatic play(input int n);
        int lim;
        lim = (n < 0 || n > trace.size()) ? trace.size() : n;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk); #1;
            reset   = 1'b0;
            MOC     = trace[i].moc;
            zero    = trace[i].zero;
            opcode  = trace[i].opc;
            cur_exp = trace[i].exp;
            chk_en  = 1'b1;
        end
        trace.delete();
        @(negedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            reset   = 1'b1;
            MOC     = rb();
            opcode  = ropc();
            cur_exp = '0;
            chk_en  = 1'b1;
        end
        @(negedge clk); #1;
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic run_instr(input string name, input int op, input int df, input int dd,
                             input logic z, input int exp_lat);
        bit f;
        build(op, df, dd, z, f);
        play(-1);
        chk(name, last_lat, exp_lat);
    endtask

    initial begin
        bit f;
        int len, op, df, dd;

        do_reset(2);

        run_instr("lat_add", 0, 0, 0, 1'b0, 5);
        run_instr("lat_lw_moc3", 4, 0, 3, 1'b0, 9);
        chk("lw_mwait_mov_cycles", last_run, 4);
        run_instr("lat_beq_z1", 6, 0, 0, 1'b1, 4);
        run_instr("lat_beq_z0", 6, 0, 0, 1'b0, 4);
        run_instr("lat_jal", 3, 0, 0, 1'b0, 4);
        run_instr("lat_j", 2, 0, 0, 1'b0, 3);
        run_instr("lat_sli", 1, 0, 0, 1'b0, 5);
        run_instr("lat_sw", 5, 0, 0, 1'b0, 5);
        run_instr("lat_sw_fetch2", 5, 2, 0, 1'b0, 7);
        run_instr("lat_j_moc_at_limit", 2, TMO - 1, 0, 1'b0, 3 + TMO - 1);

        build(0, 99, 0, 1'b0, f);
        play(-1);
        chk("timeout_wait_cycles", last_run, 15);
        chk("timeout_fault_sticky", int'(fault), 1);
        do_reset(1);

        build(7, 0, 0, 1'b0, f);
        play(-1);
        chk("illegal_op7_fault", int'(fault), 1);
        do_reset(1);

        build(4, 0, 10, 1'b0, f);
        play(6);
        do_reset(1);
        run_instr("after_mid_wait_reset", 0, 0, 0, 1'b0, 5);

        for (int k = 0; k < 300; k++) begin
            op = ($urandom_range(0, 19) == 0) ? int'($urandom_range(7, 63)) : int'($urandom_range(0, 6));
            df = ($urandom_range(0, 24) == 0) ? 40 : int'($urandom_range(0, 3));
            dd = ($urandom_range(0, 24) == 0) ? 40 : int'($urandom_range(0, 3));
            build(op, df, dd, rb(), f);
            len = trace.size();
            if (f) begin
                play(-1);
                do_reset(1);
            end else if ($urandom_range(0, 15) == 0) begin
                play(int'($urandom_range(1, len - 1)));
                do_reset(1);
            end else begin
                play(-1);
                chk("random_latency", last_lat, len);
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
